dac_output_stage: RTL and testbench

DAC_OUTPUT_STAGE -- requirements
Module: dac_output_stage

---
 rtl/dac_output_stage.sv | 143 ++++++++++++++
 tb/tb_dac_output_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_output_stage.sv
// DAC output stage: triggered start with programmable skew, 2-entry skid FIFO,
// and a continuous output stream that pads with zero words when starved.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a trigger rising edge; output zeros, accept nothing
// DELAY | counting down the start skew; output zeros, accept nothing
// RUN   | streaming; FIFO head or zero (underrun) loaded on each DAC ready
module dac_output_stage #(
  parameter int DELAY_W = 8,
  parameter int UCNT_W  = 16
) (
  input  logic               pl_clk,
  input  logic               rst,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] delay_cycles,
  input  logic [255:0]       s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [255:0]       m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               running,
  output logic [UCNT_W-1:0]  underrun_count,
  output logic               underrun_flag
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [DELAY_W-1:0] cnt, cnt_nxt;
  logic               trig_q;
  logic [1:0]         fill;
  logic [255:0]       fifo0, fifo1;

  logic trig_rise, trig_fall, in_run, accept, pop, bypass, push, underrun, flush;

  assign trig_rise = trigger & ~trig_q;
  assign trig_fall = ~trigger & trig_q;
  assign in_run    = (state == RUN);

  // Gating with rst keeps the upstream stalled during the reset cycle itself.
  assign s_axis_tready = in_run & trigger & (fill != 2'd2) & ~rst;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pop           = m_axis_tready & in_run & (fill != 2'd0);
  assign bypass        = m_axis_tready & in_run & (fill == 2'd0) & accept;
  assign push          = accept & ~bypass;
  assign underrun      = m_axis_tready & in_run & (fill == 2'd0) & ~accept;
  assign flush         = trig_fall & (state != IDLE);
  assign running       = in_run;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (trig_rise) begin
          if (delay_cycles == '0) begin
            state_nxt = RUN;
          end else begin
            state_nxt = DELAY;
            cnt_nxt   = delay_cycles;
          end
        end
      end
      DELAY: begin
        cnt_nxt = cnt - DELAY_W'(1);
        if (trig_fall) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DELAY_W'(1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (trig_fall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pl_clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      trig_q         <= 1'b0;
      fill           <= 2'd0;
      fifo0          <= '0;
      fifo1          <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      underrun_count <= '0;
      underrun_flag  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      trig_q        <= trigger;
      m_axis_tvalid <= 1'b1;

      if (m_axis_tready) begin
        if (pop)         m_axis_tdata <= fifo0;
        else if (bypass) m_axis_tdata <= s_axis_tdata;
        else             m_axis_tdata <= '0;
      end

      // Shift-register FIFO: fifo0 is always the head.
      if (flush) begin
        fill <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (fill == 2'd0) fifo0 <= s_axis_tdata;
            else              fifo1 <= s_axis_tdata;
            fill <= fill + 2'd1;
          end
          2'b01: begin
            fifo0 <= fifo1;
            fill  <= fill - 2'd1;
          end
          2'b11: begin
            if (fill == 2'd1) fifo0 <= s_axis_tdata;
            else begin
              fifo0 <= fifo1;
              fifo1 <= s_axis_tdata;
            end
          end
          default: ;
        endcase
      end

      if (trig_rise) begin
        underrun_count <= '0;
        underrun_flag  <= 1'b0;
      end else if (underrun) begin
        if (~&underrun_count) underrun_count <= underrun_count + UCNT_W'(1);
        underrun_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_output_stage.sv
// Scoreboarded bench for dac_output_stage: directed vectors push expected output
// words; a monitor pops one per DAC-ready cycle and compares.
module tb_dac_output_stage;
  localparam int DW = 8;
  localparam int UW = 2;

  logic          pl_clk = 1'b0;
  logic          rst;
  logic          trigger;
  logic [DW-1:0] delay_cycles;
  logic [255:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [255:0]  m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          running;
  logic [UW-1:0] underrun_count;
  logic          underrun_flag;

  logic [255:0]  exp_q[$];
  logic          mon_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  logic [255:0] w1 = {8{32'h0000_0001}};
  logic [255:0] w2 = {8{32'h0000_0002}};
  logic [255:0] w3 = {8{32'h0000_0003}};
  logic [255:0] wa = {8{32'hA5A5_000A}};
  logic [255:0] wb = {8{32'h5A5A_000B}};
  logic [255:0] wc = {8{32'hC3C3_000C}};
  logic [255:0] wd = {8{32'hDDDD_000D}};
  logic [255:0] we = {8{32'hEEEE_000E}};
  logic [255:0] wf = {8{32'hF0F0_000F}};
  logic [255:0] wg = {8{32'h1234_5678}};

  always #5 pl_clk = ~pl_clk;

  dac_output_stage #(.DELAY_W(DW), .UCNT_W(UW)) dut (
    .pl_clk        (pl_clk),
    .rst           (rst),
    .trigger       (trigger),
    .delay_cycles  (delay_cycles),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .running       (running),
    .underrun_count(underrun_count),
    .underrun_flag (underrun_flag)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pl_clk);
    #2;
  endtask

  // Monitor: every edge where the DAC was ready produces one new output word.
  initial begin
    logic         take;
    logic [255:0] e;
    forever begin
      @(posedge pl_clk);
      take = mon_en && m_axis_tready;
      @(negedge pl_clk);
      if (take) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got output %0h with no expected word", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("m_axis_tdata", m_axis_tdata, e);
          check("m_axis_tvalid", m_axis_tvalid, 1'b1);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; trigger = 1'b0; delay_cycles = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    step(); step();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_running", running, 1'b0);
    check("rst_ucount", underrun_count, '0);
    check("rst_uflag", underrun_flag, 1'b0);
    check("rst_tready", s_axis_tready, 1'b0);
    rst = 1'b0;
    step();
    check("tvalid_after_rst", m_axis_tvalid, 1'b1);

    // Delayed start: 5-cycle skew, RUN six cycles after the edge
    m_axis_tready = 1'b0; delay_cycles = 8'd5; trigger = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("delay_tready", s_axis_tready, 1'b0);
      check("delay_running", running, 1'b0);
      step();
    end
    check("delay_running_end", running, 1'b1);
    check("run_tready", s_axis_tready, 1'b1);

    // Streaming with one-cycle latency via bypass
    m_axis_tready = 1'b1; mon_en = 1'b1; s_axis_tvalid = 1'b1;
    s_axis_tdata = w1; exp_q.push_back(w1); step();
    s_axis_tdata = w2; exp_q.push_back(w2); step();
    s_axis_tdata = w3; exp_q.push_back(w3); step();
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b0; mon_en = 1'b0;
    check("stream_ucount", underrun_count, '0);
    check("stream_uflag", underrun_flag, 1'b0);

    // Backpressure: two words buffered, then stall upstream
    s_axis_tvalid = 1'b1; s_axis_tdata = wa; step();
    s_axis_tdata = wb; step();
    s_axis_tdata = wc; #1;
    check("bp_tready_full0", s_axis_tready, 1'b0);
    step();
    check("bp_tready_full1", s_axis_tready, 1'b0);
    step();
    m_axis_tready = 1'b1; s_axis_tvalid = 1'b0; mon_en = 1'b1;
    exp_q.push_back(wa); exp_q.push_back(wb);
    step();
    // accept and pop in the same cycle
    s_axis_tvalid = 1'b1; s_axis_tdata = wc; exp_q.push_back(wc);
    step();
    s_axis_tvalid = 1'b0;
    step();
    m_axis_tready = 1'b0; mon_en = 1'b0;
    check("bp_ucount", underrun_count, '0);

    // Underrun: three zero words
    m_axis_tready = 1'b1; mon_en = 1'b1;
    repeat (3) begin exp_q.push_back('0); step(); end
    m_axis_tready = 1'b0; mon_en = 1'b0;
    check("ur_ucount", underrun_count, 2'd3);
    check("ur_uflag", underrun_flag, 1'b1);

    // Saturation at 2'b11 after two more underruns
    m_axis_tready = 1'b1; mon_en = 1'b1;
    repeat (2) begin exp_q.push_back('0); step(); end
    m_axis_tready = 1'b0; mon_en = 1'b0;
    check("sat_ucount", underrun_count, 2'd3);

    // Stop with a full FIFO
    s_axis_tvalid = 1'b1; s_axis_tdata = wd; step();
    s_axis_tdata = we; step();
    trigger = 1'b0; #1;
    check("stop_tready", s_axis_tready, 1'b0);
    step();
    check("stop_running", running, 1'b0);
    check("stop_tready_idle", s_axis_tready, 1'b0);
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; mon_en = 1'b1;
    exp_q.push_back('0); exp_q.push_back('0);
    step(); step();
    m_axis_tready = 1'b0; mon_en = 1'b0;
    check("idle_no_underrun", underrun_count, 2'd3);
    check("idle_uflag", underrun_flag, 1'b1);

    // Restart with zero delay: counters cleared, flushed words gone
    delay_cycles = '0; trigger = 1'b1;
    step();
    check("restart_running", running, 1'b1);
    check("restart_ucount", underrun_count, '0);
    check("restart_uflag", underrun_flag, 1'b0);
    m_axis_tready = 1'b1; mon_en = 1'b1; exp_q.push_back('0);
    step();
    m_axis_tready = 1'b0; mon_en = 1'b0;
    check("restart_underrun", underrun_count, 2'd1);

    // Reset mid-RUN with a buffered word
    s_axis_tvalid = 1'b1; s_axis_tdata = wf; m_axis_tready = 1'b1; mon_en = 1'b1;
    exp_q.push_back(wf);
    step();
    s_axis_tdata = wg; m_axis_tready = 1'b0; mon_en = 1'b0;
    step();
    s_axis_tvalid = 1'b0; rst = 1'b1;
    step();
    check("mid_rst_tdata", m_axis_tdata, '0);
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_running", running, 1'b0);
    check("mid_rst_ucount", underrun_count, '0);
    check("mid_rst_uflag", underrun_flag, 1'b0);
    check("mid_rst_tready", s_axis_tready, 1'b0);
    rst = 1'b0;
    step();
    check("mid_rst_tvalid_rel", m_axis_tvalid, 1'b1);
    check("mid_rst_rerun", running, 1'b1);
    m_axis_tready = 1'b1; mon_en = 1'b1; exp_q.push_back('0);
    step();
    m_axis_tready = 1'b0; mon_en = 1'b0;
    step(); step();
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
